// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the MEM stage, the external requester, the arbiter and Data_Memory.
// The arbiter sits on the slave side; CPU, EXT and the memory together form the master side.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_gnt;
  logic [DATA_W-1:0] ext_rdata;
  logic              ext_valid;
  logic              ext_err;

  logic              dm_mem_read;
  logic              dm_mem_write;
  logic [ADDR_W-1:0] dm_address;
  logic [DATA_W-1:0] dm_write_data;
  logic [DATA_W-1:0] dm_read_data;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ext_req, ext_we, ext_addr, ext_wdata,
    output dm_read_data,
    input  cpu_rdata, cpu_stall,
    input  ext_gnt, ext_rdata, ext_valid, ext_err,
    input  dm_mem_read, dm_mem_write, dm_address, dm_write_data
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    input  dm_read_data,
    output cpu_rdata, cpu_stall,
    output ext_gnt, ext_rdata, ext_valid, ext_err,
    output dm_mem_read, dm_mem_write, dm_address, dm_write_data
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU has default priority, EXT gets capped bursts plus starvation protection.
// Define DMEM_ARB_PROTECT_EN to block (and flag) EXT writes below PROT_BASE.
module dmem_arbiter #(
  parameter int                ADDR_W       = 8,
  parameter int                DATA_W       = 8,
  parameter int                STARVE_LIMIT = 4,
  parameter int                EXT_BURST    = 4,
  parameter logic [ADDR_W-1:0] PROT_BASE    = 'h10
) (
  input  logic          clock,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);

  typedef enum logic {ARB_CPU, ARB_EXT} arb_state_t;

  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
  localparam int BEAT_W = $clog2(EXT_BURST + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(STARVE_LIMIT - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(EXT_BURST - 1);

  arb_state_t        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [BEAT_W-1:0] beat_cnt;
  logic              ext_own;
  logic              ext_beat;
  logic              ext_blocked;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;

  assign ext_own  = (state == ARB_EXT);
  assign ext_beat = ext_own & bus.ext_req;

`ifdef DMEM_ARB_PROTECT_EN
  assign ext_blocked = bus.ext_we & (bus.ext_addr < PROT_BASE);
`else
  logic unused_prot_base;
  assign ext_blocked      = 1'b0;
  assign unused_prot_base = ^PROT_BASE;
`endif

  always_comb begin
    addr_sel         = ext_own ? bus.ext_addr  : bus.cpu_addr;
    wdata_sel        = ext_own ? bus.ext_wdata : bus.cpu_wdata;
    bus.dm_mem_read  = 1'b0;
    bus.dm_mem_write = 1'b0;
    if (!reset) begin
      if (ext_own) begin
        bus.dm_mem_read  = bus.ext_req & ~bus.ext_we;
        bus.dm_mem_write = bus.ext_req & bus.ext_we & ~ext_blocked;
      end else begin
        bus.dm_mem_read  = bus.cpu_req & ~bus.cpu_we;
        bus.dm_mem_write = bus.cpu_req & bus.cpu_we;
      end
    end
  end

  assign bus.dm_address    = addr_sel;
  assign bus.dm_write_data = wdata_sel;
  assign bus.cpu_rdata     = bus.dm_read_data;
  assign bus.cpu_stall     = ext_own & bus.cpu_req;
  assign bus.ext_gnt       = ext_own;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ARB_CPU;
      wait_cnt      <= '0;
      beat_cnt      <= '0;
      bus.ext_rdata <= '0;
      bus.ext_valid <= 1'b0;
      bus.ext_err   <= 1'b0;
    end else begin
      bus.ext_valid <= ext_beat & ~bus.ext_we;
      bus.ext_err   <= ext_beat & bus.ext_we & ext_blocked;
      if (ext_beat && !bus.ext_we)
        bus.ext_rdata <= bus.dm_read_data;

      unique case (state)
        ARB_CPU: begin
          // The CPU access in the cycle that hands over still completes; EXT takes the next cycle.
          if (!bus.ext_req) begin
            wait_cnt <= '0;
          end else if (!bus.cpu_req || wait_cnt == WAIT_LAST) begin
            state    <= ARB_EXT;
            wait_cnt <= '0;
            beat_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ARB_EXT: begin
          if (!bus.ext_req) begin
            state <= ARB_CPU;
          end else if (beat_cnt == BEAT_LAST) begin
            state    <= ARB_CPU;
            beat_cnt <= '0;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
